// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - op encodings and FSM state type shared by the multi-cycle shifter
package shifter_pkg;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // True for ops whose shifted-out bits leave through the MSB.
  function automatic logic op_is_left(logic [1:0] op);
    return (op == OP_ROL) || (op == OP_SLL);
  endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational shift/rotate of one operand by 0..STEP positions
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 2,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       op,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] res,
  output logic             carry
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Each legal amount is a constant shift; k selects one of them.
  always_comb begin
    res   = data;
    carry = 1'b0;
    for (int i = 1; i <= STEP; i++) begin
      if (k == KW'(i)) begin
        case (op)
          OP_ROL:  res = (data << i) | (data >> (WIDTH - i));
          OP_SLL:  res = data << i;
          OP_SRA:  res = $signed(data) >>> i;
          default: res = data >> i;
        endcase
        if (op_is_left(op))
          carry = |(data & (ONE << (WIDTH - i)));
        else
          carry = |(data & (ONE << (i - 1)));
      end
    end
  end

endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle shifter, at most STEP positions per clock, valid/ready in and out
// Optional result flags (out_zero, out_carry) enabled by SEQ_SHIFTER_FLAGS_EN.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 2,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic [CNTW-1:0]  in_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SEQ_SHIFTER_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_carry
`endif
);

  localparam int KW = $clog2(STEP + 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  data_q;
  logic [1:0]        op_q;
  logic [CNTW-1:0]   rem_q;
  logic [KW-1:0]     k;
  logic [WIDTH-1:0]  step_data;
  logic              last_step;
  logic              accept;

  always_comb begin
    if (rem_q > CNTW'(STEP))
      k = KW'(STEP);
    else
      k = KW'(rem_q);
  end

  assign last_step = (rem_q == CNTW'(k));
  assign accept    = (state_q == IDLE) && in_valid;
  assign out_data  = data_q;

`ifdef SEQ_SHIFTER_FLAGS_EN
  logic step_carry;
  logic zero_q, carry_q;

  shift_step #(.WIDTH(WIDTH), .STEP(STEP), .KW(KW)) u_step (
    .data  (data_q),
    .op    (op_q),
    .k     (k),
    .res   (step_data),
    .carry (step_carry)
  );
`else
  shift_step #(.WIDTH(WIDTH), .STEP(STEP), .KW(KW)) u_step (
    .data  (data_q),
    .op    (op_q),
    .k     (k),
    .res   (step_data),
    .carry ()
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_d = (in_cnt == '0) ? DONE : BUSY;
      end
      BUSY: begin
        if (last_step)
          state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      op_q   <= OP_ROL;
      rem_q  <= '0;
    end else if (accept) begin
      data_q <= in_data;
      op_q   <= in_op;
      rem_q  <= in_cnt;
    end else if (state_q == BUSY) begin
      data_q <= step_data;
      rem_q  <= rem_q - CNTW'(k);
    end
  end

`ifdef SEQ_SHIFTER_FLAGS_EN
  // Flags are captured on the edge that enters DONE so they stay stable with out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (accept) begin
      zero_q  <= (in_data == '0);
      carry_q <= 1'b0;
    end else if (state_q == BUSY && last_step) begin
      zero_q  <= (step_data == '0);
      carry_q <= step_carry;
    end
  end

  assign out_zero  = zero_q;
  assign out_carry = carry_q;
`endif

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - scoreboard bench for seq_shifter (WIDTH=16, STEP=2), flags under SEQ_SHIFTER_FLAGS_EN
module tb_seq_shifter;

  localparam int WIDTH = 16;
  localparam int STEP  = 2;
  localparam int CNTW  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_op;
  logic [CNTW-1:0]  in_cnt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef SEQ_SHIFTER_FLAGS_EN
  logic             out_zero;
  logic             out_carry;
`endif

  typedef struct {
    logic [15:0] data;
    logic        carry;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_cnt    (in_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SEQ_SHIFTER_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_carry (out_carry)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_shift(logic [15:0] d, logic [1:0] op, int c);
    logic [15:0] r;
    case (op)
      2'b00:   r = (c == 0) ? d : ((d << c) | (d >> (16 - c)));
      2'b01:   r = d << c;
      2'b10:   r = $signed(d) >>> c;
      default: r = d >> c;
    endcase
    return r;
  endfunction

  function automatic logic ref_carry(logic [15:0] d, logic [1:0] op, int c);
    logic [15:0] m;
    if (c == 0) return 1'b0;
    if (op == 2'b00 || op == 2'b01) m = 16'h1 << (16 - c);
    else                            m = 16'h1 << (c - 1);
    return |(d & m);
  endfunction

  task automatic run(input logic [15:0] d, input logic [1:0] op, input int c,
                     input int hold, input bit noise);
    exp_t e;
    int   lat;
    logic [15:0] held;
    @(negedge clk);
    check("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = d; in_op = op; in_cnt = CNTW'(c);
    e.data  = ref_shift(d, op, c);
    e.carry = ref_carry(d, op, c);
    e.lat   = 1 + (c + STEP - 1) / STEP;
    sb.push_back(e);
    @(posedge clk); #1;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      in_valid = noise;
      in_data  = 16'($urandom);
      in_op    = 2'($urandom);
      in_cnt   = CNTW'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", {31'b0, out_valid}, 32'd1);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    check("out_data", {16'b0, out_data}, {16'b0, e.data});
    check("latency", lat, e.lat);
    check("in_ready_done", {31'b0, in_ready}, 32'd0);
`ifdef SEQ_SHIFTER_FLAGS_EN
    check("out_zero", {31'b0, out_zero}, {31'b0, (e.data == 16'h0)});
    check("out_carry", {31'b0, out_carry}, {31'b0, e.carry});
`endif
    held = out_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_data", {16'b0, out_data}, {16'b0, held});
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", {31'b0, in_ready}, 32'd1);
    check("release_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_op = '0; in_cnt = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", {16'b0, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(16'h8001, 2'b00, 3, 0, 1'b0);
    run(16'h8000, 2'b10, 15, 0, 1'b0);
    run(16'h8000, 2'b11, 15, 0, 1'b1);
    run(16'h0001, 2'b01, 15, 0, 1'b0);
    run(16'h1234, 2'b10, 0, 0, 1'b0);
    run(16'hA5C3, 2'b00, 7, 5, 1'b1);
    run(16'h8000, 2'b01, 1, 0, 1'b0);
    run(16'h0002, 2'b11, 1, 0, 1'b0);
    for (int n = 0; n < 24; n++)
      run(16'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 15),
          $urandom_range(0, 2), 1'($urandom));

    // Reset during the second BUSY cycle of a long request.
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'hF00F; in_op = 2'b01; in_cnt = 4'd15;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #2;
    check("pre_rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_out_data", {16'b0, out_data}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run(16'h00FF, 2'b11, 4, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
